astropix_layers_frame_mux: RTL

- Downstream neighbour of the per-layer SPI protocol stage. Merges the framed AXIS byte streams of LAYER_COUNT layers into one AXIS stream feeding the readout FIFO.
- Frames are atomic: once a layer is granted, all its bytes through tlast are forwarded before arbitration resumes.
- Arbitration is round-robin with per-layer enables. A frame-length watchdog protects the FIFO from a layer that never asserts tlast.

---
 rtl/astropix_layers_frame_mux_pkg.sv | 14 +
 rtl/astropix_layers_frame_mux_arbiter.sv | 33 +++
 rtl/astropix_layers_frame_mux.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/astropix_layers_frame_mux_pkg.sv
// rtl/astropix_layers_frame_mux_pkg.sv - shared types and constants for the layer frame mux
package astropix_frame_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DRAIN   = 2'd2
  } frame_mux_state_t;

  localparam int MUX_MAX_LAYERS = 8;
  localparam int GRANT_W        = $clog2(MUX_MAX_LAYERS);
  localparam logic [7:0] STALL_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/astropix_layers_frame_mux_arbiter.sv
// rtl/astropix_layers_frame_mux_arbiter.sv - combinational round-robin pick starting after last_grant
module frame_mux_rr_arbiter
  import astropix_frame_mux_pkg::*;
#(
  parameter int LAYER_COUNT = 3
) (
  input  logic [LAYER_COUNT-1:0] i_req,
  input  logic [GRANT_W-1:0]     i_last_grant,
  output logic [GRANT_W-1:0]     o_winner,
  output logic                   o_winner_valid
);

  int w_pos;

  always_comb begin
    o_winner       = '0;
    o_winner_valid = 1'b0;
    w_pos          = 0;
    for (int k = 1; k <= LAYER_COUNT; k++) begin
      w_pos = int'(i_last_grant) + k;
      if (w_pos >= LAYER_COUNT) begin
        w_pos = w_pos - LAYER_COUNT;
      end
      for (int i = 0; i < LAYER_COUNT; i++) begin
        if (!o_winner_valid && (w_pos == i) && i_req[i]) begin
          o_winner_valid = 1'b1;
          o_winner       = GRANT_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/astropix_layers_frame_mux.sv
// rtl/astropix_layers_frame_mux.sv - frame-atomic round-robin merge of per-layer AXIS byte streams
// Optional stall watchdog: define ASTROPIX_FRAME_MUX_STALL_TIMEOUT_EN.
module astropix_layers_frame_mux
  import astropix_frame_mux_pkg::*;
#(
  parameter int LAYER_COUNT     = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int DEST_WIDTH      = 8,
  parameter int MAX_FRAME_BYTES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LAYER_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LAYER_COUNT-1:0]            s_axis_tvalid,
  output logic [LAYER_COUNT-1:0]            s_axis_tready,
  input  logic [LAYER_COUNT-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [DEST_WIDTH-1:0]             m_axis_tdest,
  input  logic [LAYER_COUNT-1:0]            cfg_layer_enable,
`ifdef ASTROPIX_FRAME_MUX_STALL_TIMEOUT_EN
  input  logic [15:0]                       cfg_stall_timeout,
`endif
  output logic [2:0]                        status_active_layer,
  output logic                              status_busy,
  output logic                              stat_frame_forwarded,
  output logic                              stat_frame_truncated
);

  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);

  frame_mux_state_t r_state;
  frame_mux_state_t w_state_next;

  logic [GRANT_W-1:0]    r_grant;
  logic [GRANT_W-1:0]    r_last_grant;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [DEST_WIDTH-1:0] r_m_tdest;
  logic                  r_trunc;

  logic [LAYER_COUNT-1:0] w_req;
  logic [GRANT_W-1:0]     w_winner;
  logic                   w_winner_valid;
  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic                   w_m_free;
  logic                   w_in_hs;
  logic                   w_wdog;
  logic                   w_load;
  logic                   w_load_last;
  logic [DATA_WIDTH-1:0]  w_load_data;
  logic                   w_trunc;
  logic                   w_arb_take;

  assign w_req = s_axis_tvalid & cfg_layer_enable;

  frame_mux_rr_arbiter #(
    .LAYER_COUNT(LAYER_COUNT)
  ) u_arbiter (
    .i_req          (w_req),
    .i_last_grant   (r_last_grant),
    .o_winner       (w_winner),
    .o_winner_valid (w_winner_valid)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < LAYER_COUNT; i++) begin
      if (r_grant == GRANT_W'(i)) begin
        w_sel_valid = s_axis_tvalid[i];
        w_sel_last  = s_axis_tlast[i];
        w_sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Single-entry output register: it can take a byte when empty or when it empties this cycle.
  assign w_m_free = !r_m_tvalid || m_axis_tready;
  assign w_in_hs  = (r_state == FORWARD) && w_sel_valid && w_m_free;
  assign w_wdog   = (r_byte_cnt + CNT_W'(1)) == CNT_W'(MAX_FRAME_BYTES);

`ifdef ASTROPIX_FRAME_MUX_STALL_TIMEOUT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall_fire;

  always_ff @(posedge clk) begin
    if (rst || (r_state != FORWARD) || w_in_hs) begin
      r_stall_cnt <= '0;
    end else if (!w_sel_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign w_stall_fire = (cfg_stall_timeout != 16'd0) && (r_stall_cnt >= cfg_stall_timeout);
`endif

  always_comb begin
    w_state_next  = r_state;
    s_axis_tready = '0;
    w_load        = 1'b0;
    w_load_last   = w_sel_last;
    w_load_data   = w_sel_data;
    w_trunc       = 1'b0;
    w_arb_take    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_winner_valid) begin
          w_arb_take   = 1'b1;
          w_state_next = FORWARD;
        end
      end
      FORWARD: begin
        for (int i = 0; i < LAYER_COUNT; i++) begin
          if (r_grant == GRANT_W'(i)) begin
            s_axis_tready[i] = w_m_free;
          end
        end
        if (w_in_hs) begin
          w_load = 1'b1;
          if (w_sel_last) begin
            w_state_next = IDLE;
          end else if (w_wdog) begin
            w_load_last  = 1'b1;
            w_trunc      = 1'b1;
            w_state_next = DRAIN;
          end
        end
`ifdef ASTROPIX_FRAME_MUX_STALL_TIMEOUT_EN
        else if (w_stall_fire && w_m_free) begin
          w_load       = 1'b1;
          w_load_last  = 1'b1;
          w_load_data  = DATA_WIDTH'(STALL_FILL_BYTE);
          w_trunc      = 1'b1;
          w_state_next = DRAIN;
        end
`endif
      end
      DRAIN: begin
        for (int i = 0; i < LAYER_COUNT; i++) begin
          if (r_grant == GRANT_W'(i)) begin
            s_axis_tready[i] = 1'b1;
          end
        end
        if (w_sel_valid && w_sel_last) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= GRANT_W'(LAYER_COUNT - 1);
      r_byte_cnt   <= '0;
      r_m_tdata    <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdest    <= '0;
      r_trunc      <= 1'b0;
    end else begin
      if (w_arb_take) begin
        r_grant      <= w_winner;
        r_last_grant <= w_winner;
        r_byte_cnt   <= '0;
      end else if (w_in_hs) begin
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
      if (w_load) begin
        r_m_tdata  <= w_load_data;
        r_m_tlast  <= w_load_last;
        r_m_tdest  <= DEST_WIDTH'(r_grant);
        r_m_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      r_trunc <= w_trunc;
    end
  end

  assign m_axis_tdata         = r_m_tdata;
  assign m_axis_tvalid        = r_m_tvalid;
  assign m_axis_tlast         = r_m_tlast;
  assign m_axis_tdest         = r_m_tdest;
  assign status_active_layer  = r_grant;
  assign status_busy          = (r_state != IDLE);
  assign stat_frame_forwarded = r_m_tvalid && m_axis_tready && r_m_tlast;
  assign stat_frame_truncated = r_trunc;

endmodule
